// File: rtl/arrayed_mem_wr_sched_pkg.sv
// Shared types and default sizing for the arrayed memory write scheduler.
// Also provides a helper that sizes the requester index.
package arrayed_mem_wr_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int WIDTH_DEF   = 2;
  localparam int ADDR_W_DEF  = 2;
  localparam int CNT_W       = ADDR_W_DEF;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arrayed_mem_wr_sched_rr_pick.sv
// Combinational round-robin picker.
// Returns the first eligible requester at or after ptr, wrapping around.
module rr_pick
  import arrayed_mem_wr_sched_pkg::*;
#(
  parameter int N     = NUM_REQ_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int j;

  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    idx    = '0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && elig[j]) begin
        valid     = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arrayed_mem_wr_sched.sv
// Round-robin write scheduler for a small register array with a sequenced clear.
// The whole array is exported combinationally, entry 0 at the MSBs.
//
// state    | meaning
// ST_ARB   | one round-robin write per cycle; clr starts a clear
// ST_CLEAR | zero one entry per cycle, busy high, no grants
module arrayed_mem_wr_sched
  import arrayed_mem_wr_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]  wdata,
  input  logic                      clr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [DEPTH*WIDTH-1:0]    out
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]   ptr, ptr_nxt, win_idx;
  logic [ADDR_W-1:0]  cnt, cnt_nxt;
  logic [NUM_REQ-1:0] elig, win_oh, gnt_nxt;
  logic               win_vld, busy_nxt, wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;

  // The requester just acknowledged may still hold req this cycle; mask it.
  assign elig = req & ~gnt;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .elig   (elig),
    .ptr    (ptr),
    .onehot (win_oh),
    .valid  (win_vld),
    .idx    (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ARB;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    busy_nxt  = busy;
    wr_en     = 1'b0;
    wr_addr   = addr[win_idx*ADDR_W +: ADDR_W];
    wr_data   = wdata[win_idx*WIDTH +: WIDTH];
    case (state)
      ST_ARB: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else if (win_vld) begin
          wr_en   = 1'b1;
          gnt_nxt = win_oh;
          ptr_nxt = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = '0;
        cnt_nxt = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_ARB;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < DEPTH; i++) out[(DEPTH-1-i)*WIDTH +: WIDTH] = mem[i];
  end

endmodule

// File: tb/tb_arrayed_mem_wr_sched.sv
// Bench for arrayed_mem_wr_sched: directed scenarios plus randomized traffic
// checked against an entry-level model of the scheduler.
module tb_arrayed_mem_wr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       clr;
  wire  [3:0] gnt;
  wire        busy;
  wire  [7:0] out;

  int n_cmp  = 0;
  int n_fail = 0;

  // model: entry array, rr pointer, last grant, entries left to clear
  logic [1:0] m_mem [4];
  int         m_ptr;
  logic [3:0] m_gnt;
  int         m_clr_left;

  arrayed_mem_wr_sched dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .addr  (addr),
    .wdata (wdata),
    .clr   (clr),
    .gnt   (gnt),
    .busy  (busy),
    .out   (out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_out();
    return {m_mem[0], m_mem[1], m_mem[2], m_mem[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 2'b00;
    m_ptr = 0;
    m_gnt = 4'b0000;
    m_clr_left = 0;
  endtask

  task automatic model_edge();
    int w;
    logic [3:0] g;
    w = -1;
    g = 4'b0000;
    if (m_clr_left > 0) begin
      m_mem[4 - m_clr_left] = 2'b00;
      m_clr_left--;
    end else if (clr) begin
      m_clr_left = 4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && req[i] && !m_gnt[i]) w = i;
      end
      if (w >= 0) begin
        m_mem[addr[w*2 +: 2]] = wdata[w*2 +: 2];
        g[w] = 1'b1;
        m_ptr = (w + 1) % 4;
      end
    end
    m_gnt = g;
  endtask

  // Advance one clock; inputs are sampled at the edge, outputs read 1 ns later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000; addr = 8'h00; wdata = 8'h00; clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    req = 4'b0001; addr[1:0] = 2'd0; wdata[1:0] = 2'b11;
    step();
    req = 4'b0000;
    if (out !== 8'hC0) begin
      n_fail++; $display("FAIL reset_pre_out: got %h want %h", out, 8'hC0);
    end
    n_cmp++;
    rst = 1'b0;
    model_reset();
    #1;
    if ({gnt, busy, out} !== 13'd0) begin
      n_fail++; $display("FAIL reset_async: gnt=%b busy=%b out=%h want all zero", gnt, busy, out);
    end
    n_cmp++;
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0100; addr[5:4] = 2'd1; wdata[5:4] = 2'b11;
    step();
    if ({gnt, busy, out} !== {4'b0100, 1'b0, 8'b00_11_00_00}) begin
      n_fail++; $display("FAIL single_write: gnt=%b busy=%b out=%h want 0100/0/30", gnt, busy, out);
    end
    n_cmp++;
    step();
    if ({gnt, out} !== {4'b0000, 8'h30}) begin
      n_fail++; $display("FAIL single_held: gnt=%b out=%h want 0000/30", gnt, out);
    end
    n_cmp++;
    req = 4'b0000;
    step();
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL single_drop: gnt=%b want 0000", gnt);
    end
    n_cmp++;
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr[i*2 +: 2] = 2'(i);
      wdata[i*2 +: 2] = 2'(3 - i);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (gnt !== 4'(1 << c)) begin
        n_fail++; $display("FAIL fair_order%0d: gnt=%b want %b", c, gnt, 4'(1 << c));
      end
      n_cmp++;
      req[c] = 1'b0;
    end
    if (out !== 8'b11_10_01_00) begin
      n_fail++; $display("FAIL fair_mem: out=%h want %h", out, 8'b11_10_01_00);
    end
    n_cmp++;
    req = 4'b1001;
    step();
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL fair_wrap: gnt=%b want 0001", gnt);
    end
    n_cmp++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_contention();
    do_reset();
    req = 4'b1001;
    addr[1:0] = 2'd3; wdata[1:0] = 2'b01;
    addr[7:6] = 2'd3; wdata[7:6] = 2'b10;
    step();
    if ({gnt, out} !== {4'b0001, 8'h01}) begin
      n_fail++; $display("FAIL cont_first: gnt=%b out=%h want 0001/01", gnt, out);
    end
    n_cmp++;
    req[0] = 1'b0;
    step();
    if ({gnt, out} !== {4'b1000, 8'h02}) begin
      n_fail++; $display("FAIL cont_second: gnt=%b out=%h want 1000/02", gnt, out);
    end
    n_cmp++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_clear();
    logic [7:0] exp_out [5];
    exp_out = '{8'hFF, 8'h3F, 8'h0F, 8'h03, 8'h00};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr[i*2 +: 2] = 2'(i);
      wdata[i*2 +: 2] = 2'b11;
    end
    for (int c = 0; c < 4; c++) begin
      step();
      req[c] = 1'b0;
    end
    if (out !== 8'hFF) begin
      n_fail++; $display("FAIL clear_fill: out=%h want FF", out);
    end
    n_cmp++;
    clr = 1'b1;
    req = 4'b0010; addr[3:2] = 2'd0; wdata[3:2] = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      clr = (c == 1);
      if ({gnt, busy, out} !== {4'b0000, (c < 4), exp_out[c]}) begin
        n_fail++;
        $display("FAIL clear_edge%0d: gnt=%b busy=%b out=%h want 0000/%0d/%h",
                 c, gnt, busy, out, (c < 4), exp_out[c]);
      end
      n_cmp++;
    end
    step();
    if ({gnt, busy, out} !== {4'b0010, 1'b0, 8'h40}) begin
      n_fail++; $display("FAIL clear_grant: gnt=%b busy=%b out=%h want 0010/0/40", gnt, busy, out);
    end
    n_cmp++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_in_clear();
    do_reset();
    req = 4'b0010; addr[3:2] = 2'd3; wdata[3:2] = 2'b11;
    step();
    req = 4'b0000;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    if ({busy, out} !== {1'b1, 8'h03}) begin
      n_fail++; $display("FAIL rstclr_pre: busy=%b out=%h want 1/03", busy, out);
    end
    n_cmp++;
    rst = 1'b0;
    model_reset();
    #1;
    if ({gnt, busy, out} !== 13'd0) begin
      n_fail++; $display("FAIL rstclr_async: gnt=%b busy=%b out=%h want all zero", gnt, busy, out);
    end
    n_cmp++;
    rst = 1'b1;
    req = 4'b1001; addr = 8'h00; wdata = 8'h01;
    step();
    if ({gnt, busy} !== {4'b0001, 1'b0}) begin
      n_fail++; $display("FAIL rstclr_regrant: gnt=%b busy=%b want 0001/0", gnt, busy);
    end
    n_cmp++;
    req = 4'b0000;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step();
      if ({gnt, busy, out} !== {m_gnt, (m_clr_left > 0), m_out()}) begin
        n_fail++;
        $display("FAIL random_c%0d: gnt=%b busy=%b out=%h want %b/%0d/%h",
                 c, gnt, busy, out, m_gnt, (m_clr_left > 0), m_out());
      end
      n_cmp++;
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || m_gnt[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          addr[i*2 +: 2] = 2'($urandom_range(0, 3));
          wdata[i*2 +: 2] = 2'($urandom_range(0, 3));
        end
      end
      clr = ($urandom_range(0, 19) == 0);
    end
    clr = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_contention();
    test_clear();
    test_reset_in_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
